// File: rtl/dectobcd_pkg.sv
// dectobcd_pkg: shared types and sizes for the debounced decimal-keypad encoder.
package dectobcd_pkg;

    localparam int KEY_W      = 10;
    localparam int BCD_W      = 4;
    localparam int ACC_DIGITS = 4;
    localparam int ACC_W      = ACC_DIGITS * BCD_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

endpackage

// File: rtl/dectobcd_keypad_key_sync.sv
// key_sync: parameterized-width two-flop synchronizer for asynchronous inputs.
module key_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops give metastability a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {W{1'b0}};
            sync_q <= {W{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dectobcd_keypad.sv
// dectobcd_keypad: debounced ten-key decimal keypad to BCD encoder with a
// valid/ready output. Optional 4-digit accumulator enabled by the macro
// DECTOBCD_ACC_EN (adds ports clr and acc).
module dectobcd_keypad
    import dectobcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key,
    input  logic             ready,
    output logic [BCD_W-1:0] bcd,
    output logic             valid,
    output logic             err,
    output logic             busy
`ifdef DECTOBCD_ACC_EN
    ,
    input  logic             clr,
    output logic [ACC_W-1:0] acc
`endif
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [KEY_W-1:0] KEY_ZERO = {KEY_W{1'b0}};

    // Index of the set bit; only called on a single-bit pattern, so OR-ing works.
    function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [KEY_W-1:0] k);
        logic [BCD_W-1:0] idx;
        idx = {BCD_W{1'b0}};
        for (int i = 0; i < KEY_W; i++) begin
            idx = idx | (k[i] ? BCD_W'(i) : {BCD_W{1'b0}});
        end
        return idx;
    endfunction

    // True when more than one key line is asserted.
    function automatic logic multi_bit(input logic [KEY_W-1:0] k);
        logic [3:0] count;
        count = 4'd0;
        for (int i = 0; i < KEY_W; i++) begin
            count = count + {3'b000, k[i]};
        end
        return (count > 4'd1);
    endfunction

    logic [KEY_W-1:0] ksync_s;
    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [KEY_W-1:0] kcap_q,   kcap_d;
    logic [BCD_W-1:0] bcd_q,    bcd_d;
    logic             valid_q,  valid_d;
    logic             err_q,    err_d;
    logic             busy_q,   busy_d;

    logic key_nz_s;
    logic key_match_s;
    logic cnt_zero_s;
    logic accept_s;
    logic reject_s;
    logic handshake_s;

    key_sync #(.W(KEY_W)) u_key_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (key),
        .q_o   (ksync_s)
    );

    assign key_nz_s    = (ksync_s != KEY_ZERO);
    assign key_match_s = (ksync_s == kcap_q);
    assign cnt_zero_s  = (cnt_q == CNT_ZERO);
    assign accept_s    = (state_q == DEBOUNCE) && key_nz_s && key_match_s && cnt_zero_s
                         && !multi_bit(kcap_q);
    assign reject_s    = (state_q == DEBOUNCE) && key_nz_s && key_match_s && cnt_zero_s
                         && multi_bit(kcap_q);
    assign handshake_s = (state_q == HOLD) && valid_q && ready;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            kcap_q  <= KEY_ZERO;
            bcd_q   <= {BCD_W{1'b0}};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kcap_q  <= kcap_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: debounce press, hold until consumed, debounce release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kcap_d  = kcap_q;
        case (state_q)
            IDLE: begin
                if (key_nz_s) begin
                    kcap_d  = ksync_s;
                    cnt_d   = CNT_LOAD;
                    state_d = DEBOUNCE;
                end else begin
                    state_d = IDLE;
                end
            end
            DEBOUNCE: begin
                if (!key_nz_s) begin
                    state_d = IDLE;
                end else if (!key_match_s) begin
                    kcap_d = ksync_s;
                    cnt_d  = CNT_LOAD;
                end else if (!cnt_zero_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (multi_bit(kcap_q)) begin
                    cnt_d   = CNT_LOAD;
                    state_d = RELEASE;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    cnt_d   = CNT_LOAD;
                    state_d = RELEASE;
                end else begin
                    state_d = HOLD;
                end
            end
            RELEASE: begin
                if (key_nz_s) begin
                    cnt_d = CNT_LOAD;
                end else if (!cnt_zero_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                kcap_d  = KEY_ZERO;
            end
        endcase
    end

    // Output next values: load digit on acceptance, drop valid on handshake.
    always_comb begin
        bcd_d   = bcd_q;
        valid_d = valid_q;
        err_d   = reject_s;
        busy_d  = (state_d != IDLE);
        if (accept_s) begin
            bcd_d   = onehot_to_bcd(kcap_q);
            valid_d = 1'b1;
        end else if (handshake_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    assign bcd   = bcd_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = busy_q;

`ifdef DECTOBCD_ACC_EN
    logic [ACC_W-1:0] acc_q, acc_d;

    // Accumulator next value: clear has priority over storing a consumed digit.
    always_comb begin
        if (clr) begin
            acc_d = {ACC_W{1'b0}};
        end else if (handshake_s) begin
            acc_d = {acc_q[ACC_W-BCD_W-1:0], bcd_q};
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
`endif

endmodule

// File: doc/dectobcd_keypad.md
# dectobcd_keypad

Debounced decimal-keypad encoder: converts ten active-high key lines (digits 0–9) into a 4-bit BCD code. Each accepted keypress is delivered once over a valid/ready handshake. This is the input-side counterpart of the BCD-to-decimal decoder. It sits between the board push-buttons and any BCD consumer, such as the decoder, display logic, or a digit accumulator.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: number of consecutive stable synchronized samples required before a press or release is accepted; legal range 1..65535.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key  input  10  raw decimal key lines, bit i = digit i, active-high, asynchronous to clk.
- ready  input  1  consumer accepts bcd this cycle.
- bcd  output  4  encoded digit 0..9 (binary 0000..1001).
- valid  output  1  bcd holds an unconsumed keypress.
- err  output  1  one-cycle pulse: stable multi-key press rejected.
- busy  output  1  high in every state except IDLE.
- clr  input  1  (DECTOBCD_ACC_EN only) synchronous clear of acc.
- acc  output  16  (DECTOBCD_ACC_EN only) last four accepted digits, newest in [3:0].

## Operation
- key passes through a 2-flop synchronizer (ksync). All decisions use ksync only.
- A 4-state FSM (IDLE, DEBOUNCE, HOLD, RELEASE) and a down-counter cnt of width $clog2(DEBOUNCE_CYCLES+1) control acceptance.
- IDLE:
  - ksync == 0: stay.
  - ksync != 0: capture the pattern into kcap, load cnt = DEBOUNCE_CYCLES-1, go to DEBOUNCE.
- DEBOUNCE:
  - ksync == 0: go to IDLE.
  - ksync != kcap (and nonzero): recapture kcap, reload cnt.
  - ksync == kcap and cnt != 0: decrement cnt.
  - ksync == kcap and cnt == 0, exactly one bit set: load bcd with that bit's index, set valid, go to HOLD.
  - ksync == kcap and cnt == 0, more than one bit set: pulse err, go to RELEASE.
- HOLD:
  - valid stays high and bcd stays stable until the cycle where valid && ready.
  - On that cycle, clear valid and go to RELEASE.
  - Key activity is ignored in HOLD.
- RELEASE:
  - Requires ksync == 0 for DEBOUNCE_CYCLES consecutive cycles, then go to IDLE.
  - Any nonzero sample reloads cnt.
  - Holding a key therefore never produces a repeat.
- bcd retains its last value after handshake; its value is meaningful only while valid is high.
- Reset (asserted at any time, including mid-handshake):
  - state = IDLE, cnt = 0, kcap = 0, synchronizer flops = 0.
  - bcd = 0, valid = 0, err = 0, busy = 0, acc = 0.
  - Any pending digit is discarded.

## Timing
- Press latency: key stable and sampled at edge k → ksync nonzero after edge k+1 → DEBOUNCE entered at edge k+2 → valid rises at edge k+2+DEBOUNCE_CYCLES.
- err follows the same latency as valid and lasts exactly one cycle.
- The handshake completes on the edge where valid && ready. valid is low the following cycle.
- ready high before valid: the transfer happens in the first valid cycle.
- ready is not combinationally used for any output. All outputs are registered.
- Minimum spacing between two digits: 1 (handshake) + DEBOUNCE_CYCLES (release) + 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- A new press becomes visible in IDLE only after RELEASE completes.

## Configuration
- Macro DECTOBCD_ACC_EN, when defined:
  - Adds ports clr and acc and a 16-bit digit accumulator.
  - On every handshake cycle, acc <= {acc[11:0], bcd}; older digits shift out of [15:12].
  - clr sets acc to 0.
  - If clr and a handshake coincide, clr wins and the digit is not stored. The handshake itself still completes.
- Macro not defined:
  - clr and acc ports and all accumulator logic are absent.
  - All other behaviour is identical.

## Structure
- Package dectobcd_pkg holds:
  - the state enum (IDLE, DEBOUNCE, HOLD, RELEASE)
  - localparam KEY_W = 10
  - localparam BCD_W = 4
  - localparam ACC_DIGITS = 4
- Sub-module key_sync: a parameterized-width 2-flop synchronizer with async active-low reset. It is instantiated once at width KEY_W.
- The one-hot-to-BCD encoder and the multi-bit check (popcount > 1) are combinational functions inside the top module.

## Test plan
- Reset mid-HOLD: valid=1, bcd=5, assert rst_n=0 → valid=0, bcd=0, busy=0 immediately. After release, pressing key[3] yields bcd=3.
- Clean press: key=10'b00_0010_0000 (digit 5) held, ready=1, DEBOUNCE_CYCLES=4 → valid high for exactly one cycle at edge k+6 with bcd=4'b0101. No second valid while the key is held.
- Bounce: key[7] toggles every 2 cycles for 10 cycles, then holds → exactly one valid with bcd=7, no err.
- Multi-key: key[1] and key[8] held together → err pulses once, valid never rises, FSM returns to IDLE after release.
- Backpressure: digit 9 pressed with ready=0 for 20 cycles, then ready=1 → valid and bcd=9 held stable throughout, transfer on the first ready cycle.
- Accumulator (DECTOBCD_ACC_EN): enter 1,2,3,4,5 → acc=16'h2345. Then clr=1 → acc=0. clr coincident with the handshake of digit 6 → acc stays 0.
